// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: decode-stage sequencer with opcode classification, immediate build and a two-entry skid buffer
module id_stage_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [2:0]       out_extop,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);
  // state bits are {main_valid, skid_valid}, so outputs come straight from flops
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [2:0]      extop;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } pkt_t;
  state_t          r_state, w_next;
  pkt_t            r_main, r_skid, w_dec;
  logic [CNT_W-1:0] r_stall;
  logic            w_acc, w_cons, w_load_in, w_to_skid, w_load_skid;
  assign in_ready    = ~r_state[0];
  assign out_valid   = r_state[1];
  assign w_acc       = in_valid & in_ready & ~flush;
  assign w_cons      = out_valid & out_ready;
  assign w_load_in   = w_acc & ((r_state == EMPTY) | ((r_state == ONE) & w_cons));
  assign w_to_skid   = w_acc & (r_state == ONE) & ~w_cons;
  assign w_load_skid = w_cons & (r_state == FULL);
  assign {out_instr, out_pc, out_extop, out_imm, out_illegal} = r_main;
  assign stall_cnt   = r_stall;
  // classify the incoming opcode and build its sign-extended immediate
  always_comb begin
    w_dec       = '0;
    w_dec.instr = in_instr;
    w_dec.pc    = in_pc;
    w_dec.extop = 3'b111;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        w_dec.extop = 3'b000;
        w_dec.imm   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      end
      7'b0110111, 7'b0010111: begin
        w_dec.extop = 3'b001;
        w_dec.imm   = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
      end
      7'b0100011: begin
        w_dec.extop = 3'b010;
        w_dec.imm   = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        w_dec.extop = 3'b011;
        w_dec.imm   = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b1101111: begin
        w_dec.extop = 3'b100;
        w_dec.imm   = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011, 7'b0111011: w_dec.extop = 3'b101;
      default: ;
    endcase
    w_dec.illegal = (w_dec.extop == 3'b111);
  end
  // occupancy transitions; flush overrides everything
  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:   w_next = w_acc ? ONE : EMPTY;
      ONE:     w_next = (w_acc & ~w_cons) ? FULL : (~w_acc & w_cons) ? EMPTY : ONE;
      FULL:    w_next = w_cons ? ONE : FULL;
      default: w_next = EMPTY;
    endcase
    if (flush) w_next = EMPTY;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next;
  end
  // packet registers: main takes the new word or the skid entry, skid catches overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_in)        r_main <= w_dec;
      else if (w_load_skid) r_main <= r_skid;
      if (w_to_skid)        r_skid <= w_dec;
    end
  end
  // count cycles the held packet is refused by EX; wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall <= '0;
    else        r_stall <= r_stall + CNT_W'(out_valid & ~out_ready);
  end
endmodule

// File: tb/tb_id_stage_ctrl.sv
// tb_id_stage_ctrl: scoreboard bench for id_stage_ctrl with a queue-based reference model
module tb_id_stage_ctrl;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] in_instr = 0, out_instr, stall_cnt;
  logic [63:0] in_pc = 0, out_pc, out_imm;
  logic [2:0]  out_extop;
  int          n_chk = 0, n_fail = 0, n_deliv = 0;
  logic [31:0] m_stall = 0;
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  extop;
    logic [63:0] imm;
    logic        ill;
  } pkt_t;
  pkt_t q[$];
  logic [6:0] ops [13] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h0F, 7'h37, 7'h17,
                           7'h23, 7'h63, 7'h6F, 7'h33, 7'h3B};

  always #5 clk = ~clk;

  id_stage_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_extop(out_extop), .out_imm(out_imm), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sx(input longint unsigned v, input int n);
    longint unsigned h = 64'd1 << n;
    return (v >= (h >> 1)) ? v - h : v;
  endfunction

  // reference decode written as field arithmetic on the instruction word
  function automatic pkt_t model(input logic [31:0] w, input logic [63:0] pc);
    longint unsigned v = {32'b0, w};
    pkt_t p;
    p.instr = w; p.pc = pc; p.extop = 3'b111; p.imm = 0; p.ill = 1;
    case (w[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h0F: begin p.extop = 0; p.ill = 0; p.imm = sx(v >> 20, 12); end
      7'h37, 7'h17: begin p.extop = 1; p.ill = 0; p.imm = sx(v & 64'hFFFFF000, 32); end
      7'h23: begin p.extop = 2; p.ill = 0; p.imm = sx(((v >> 25) << 5) | ((v >> 7) & 31), 12); end
      7'h63: begin
        p.extop = 3; p.ill = 0;
        p.imm = sx((((v >> 31) & 1) << 12) | (((v >> 7) & 1) << 11) | (((v >> 25) & 63) << 5) | (((v >> 8) & 15) << 1), 13);
      end
      7'h6F: begin
        p.extop = 4; p.ill = 0;
        p.imm = sx((((v >> 31) & 1) << 20) | (((v >> 12) & 255) << 12) | (((v >> 20) & 1) << 11) | (((v >> 21) & 1023) << 1), 21);
      end
      7'h33, 7'h3B: begin p.extop = 5; p.ill = 0; end
      default: ;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 12)];
    return w;
  endfunction

  // issuer: records every accepted word and pushes its expected packet at the accepting edge
  initial begin : issuer
    logic take;
    pkt_t pk;
    forever begin
      @(negedge clk);
      take = rst_n && in_valid && in_ready && !flush;
      pk = model(in_instr, in_pc);
      @(posedge clk);
      if (take) q.push_back(pk);
    end
  end

  // monitor: compares the presented packet to the queue head, pops on handshake
  initial begin : monitor
    pkt_t h;
    bit held;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_stall = 0;
      end else begin
        held = q.size() != 0;
        chk("stall_cnt", stall_cnt, m_stall);
        chk("out_valid", out_valid, held);
        chk("in_ready", in_ready, q.size() < 2);
        if (out_valid && held) begin
          h = q[0];
          chk("pkt_instr", out_instr, h.instr);
          chk("pkt_pc", out_pc, h.pc);
          chk("pkt_extop", out_extop, h.extop);
          chk("pkt_imm", out_imm, h.imm);
          chk("pkt_illegal", out_illegal, h.ill);
          if (out_ready) begin
            void'(q.pop_front());
            n_deliv++;
          end
        end
        if (held && !out_ready) m_stall++;
        if (flush) q.delete();
      end
    end
  end

  task automatic send(input logic [31:0] w, output int cyc);
    bit acc = 0;
    in_valid = 1; in_instr = w; in_pc = {$urandom, $urandom};
    cyc = 0;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0;
    chk("accept_timeout", acc, 1);
  endtask

  task automatic directed(input logic [31:0] w, input logic [2:0] ext, input logic [63:0] imm, input logic ill);
    int c;
    send(w, c);
    chk("dir_out_valid", out_valid, 1);
    chk("dir_instr", out_instr, w);
    chk("dir_extop", out_extop, ext);
    chk("dir_imm", out_imm, imm);
    chk("dir_illegal", out_illegal, ill);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_instr"}, out_instr, 0);
    chk({tag, "_out_pc"}, out_pc, 0);
    chk({tag, "_out_extop"}, out_extop, 0);
    chk({tag, "_out_imm"}, out_imm, 0);
    chk({tag, "_out_illegal"}, out_illegal, 0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int c, d0;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1;
    out_ready = 1;
    directed(32'h00500093, 3'b000, 64'd5, 0);
    directed(32'hFFF00093, 3'b000, 64'hFFFFFFFFFFFFFFFF, 0);
    directed(32'h800000B7, 3'b001, 64'hFFFFFFFF80000000, 0);
    directed(32'hFE113C23, 3'b010, 64'hFFFFFFFFFFFFFFF8, 0);
    directed(32'hFE000EE3, 3'b011, 64'hFFFFFFFFFFFFFFFC, 0);
    directed(32'h0080006F, 3'b100, 64'd8, 0);
    directed(32'h00208033, 3'b101, 64'd0, 0);
    directed(32'h00000000, 3'b111, 64'd0, 1);
    directed(32'h0000007F, 3'b111, 64'd0, 1);
    idle(2);
    // backpressure: two accepted, third held off until EX releases
    d0 = n_deliv;
    out_ready = 0;
    a = 32'h00100093;
    send(a, c);
    send(32'h00200113, c);
    chk("bp_in_ready_low", in_ready, 0);
    in_valid = 1; in_instr = 32'h00300193;
    repeat (3) begin
      idle(1);
      chk("bp_in_ready_held", in_ready, 0);
      chk("bp_out_stable", out_instr, a);
    end
    out_ready = 1;
    send(32'h00300193, c);
    idle(4);
    chk("bp_delivered", n_deliv - d0, 3);
    // throughput: one accept per cycle with EX always ready
    d0 = n_deliv;
    for (int i = 0; i < 8; i++) begin
      send(rand_instr(), c);
      chk("tp_one_cycle", c, 1);
    end
    idle(3);
    chk("tp_delivered", n_deliv - d0, 8);
    // flush while full, with a new word offered in the flush cycle
    out_ready = 0;
    send(32'h00100093, c);
    send(32'h00200113, c);
    in_valid = 1; in_instr = 32'h7FF00213; flush = 1;
    idle(1);
    flush = 0; in_valid = 0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1;
    idle(3);
    // randomized traffic with occasional flushes
    repeat (400) begin
      in_valid  = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 15) == 0;
      in_instr  = rand_instr();
      in_pc     = {$urandom, $urandom};
      idle(1);
    end
    in_valid = 0; flush = 0; out_ready = 1;
    idle(3);
    // asynchronous reset while holding two packets
    out_ready = 0;
    send(32'h00100093, c);
    send(32'h00200113, c);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk_reset("async_rst");
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    idle(3);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
- Decode-stage sequencer between the IF stage and the EX stage of the RV64 core.
- Accepts fetched instructions over a valid/ready handshake and classifies each opcode into an immediate-format select (ExtOP).
- Builds the 64-bit immediate and presents a registered decode packet to EX, with a two-entry skid buffer so full throughput is sustained under backpressure.
- Supports pipeline flush (branch redirect) and counts backpressure stall cycles.

Parameters:
- XLEN, 64, datapath and immediate width.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- flush  input  1  discard all held instructions.
- in_valid  input  1  IF presents an instruction.
- in_ready  output  1  ID can accept this cycle.
- in_instr  input  32  instruction word.
- in_pc  input  XLEN  instruction PC.
- out_valid  output  1  decode packet valid.
- out_ready  input  1  EX accepts packet.
- out_instr  output  32  held instruction.
- out_pc  output  XLEN  held PC.
- out_extop  output  3  immediate format.
- out_imm  output  XLEN  sign-extended immediate.
- out_illegal  output  1  unrecognised encoding.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, skid empty, in_ready=1, out_instr=0, out_pc=0, out_extop=0, out_imm=0, out_illegal=0, stall_cnt=0. Reset mid-transfer drops every held instruction.
- Storage: main register (drives out_*) plus one skid register. in_ready = NOT skid_valid; it is registered, with no combinational path from out_ready.
- Accept condition: in_valid & in_ready.
- Accepted data goes into main when main is empty or is being consumed (out_valid & out_ready) this cycle and skid is empty. Otherwise it goes into skid.
- Consumption with skid full: skid moves into main. Skid empties unless a new accept refills it that same cycle. A new accept in this cycle is only possible if skid was empty at the start of the cycle.
- Latency: accept at cycle N gives out_valid=1 at cycle N+1 when main was free. Back-to-back accepts with out_ready=1 give one packet per cycle.
- Stability: while out_valid=1 and out_ready=0, all out_* fields hold constant.
- States by valid bits (main, skid):
  - EMPTY(0,0): accept -> ONE.
  - ONE(1,0): accept without consume -> FULL; consume without accept -> EMPTY; both -> ONE.
  - FULL(1,1): in_ready=0; consume -> ONE.
- Flush has priority over everything:
  - next state is EMPTY;
  - any in_valid during the flush cycle is dropped, even if in_ready=1;
  - an out_valid & out_ready handshake in the flush cycle still counts as delivered to EX.
- Decode is computed on in_instr at accept time and stored with the packet. opcode = instr[6:0].
- I-format, ExtOP 000: 0000011, 0010011, 0011011, 1100111, 1110011, 0001111.
- U-format, ExtOP 001: 0110111, 0010111.
- S-format, ExtOP 010: 0100011.
- B-format, ExtOP 011: 1100011.
- J-format, ExtOP 100: 1101111.
- R-type, ExtOP 101: 0110011, 0111011; imm=0.
- Anything else, including instr[1:0]!=11: ExtOP 111, imm=0, out_illegal=1.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - U: {instr[31:12],12'b0}.
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
- stall_cnt: increments when out_valid=1 and out_ready=0, including flush cycles. It wraps at 2^CNT_W - 1 to 0 and is cleared only by reset.

Test Plan:
- Reset then single accept: in_instr=0x00500093 (addi x1,x0,5), out_ready=1 -> out_valid=1 next cycle, out_extop=000, out_imm=5, out_illegal=0.
- Immediate formats:
  - 0xFFF00093 -> imm=0xFFFFFFFFFFFFFFFF.
  - lui 0x800000B7 -> extop=001, imm=0xFFFFFFFF80000000.
  - sd 0xFE113C23 -> extop=010, imm=-8.
  - beq 0xFE000EE3 -> extop=011, imm=-4.
  - jal 0x0080006F -> extop=100, imm=8.
- Backpressure: stream 3 instrs with out_ready=0 -> in_ready drops after the 2nd accept, 3rd held off, out_* stable, stall_cnt counts each cycle. Release out_ready -> packets delivered in order, none lost or duplicated.
- Throughput: 8 consecutive in_valid with out_ready=1 -> 8 packets on 8 consecutive cycles, in_ready never low.
- Flush in FULL state with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flush-cycle input never appears at the output.
- Illegal: in_instr=0x00000000 and 0x0000007F -> extop=111, imm=0, out_illegal=1. Assert rst_n low mid-stream -> all outputs at reset values immediately, without waiting for a clock edge.
